alu_seq_ctrl: RTL and testbench

Single-requester sequencer for the shared combinational ALU.
- Accepts one operation at a time through a valid/ready request port and drives the ALU operand, opcode and flag-input lines.
- Holds the architectural flag register (C, V, Z, S) and returns result plus flags through a valid/ready response port.
- The ALU has no divider, so this block performs division itself: WIDTH-cycle restoring division, with the quotient fed into the ALU bypass input under the divide opcode.

---
 rtl/alu_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_alu_seq_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Single-requester sequencer for the shared combinational ALU: latches one op,
// drives the ALU, runs restoring division locally, and returns result + flags.
module alu_seq_ctrl #(
  parameter int          WIDTH  = 8,
  parameter logic [5:0]  OP_DIV = 6'd14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_wf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_res,
  output logic [WIDTH-1:0] rsp_rem,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_z,
  output logic             flag_s,
  output logic [5:0]       alu_op,
  output logic             alu_ci,
  output logic             alu_vi,
  output logic             alu_zi,
  output logic             alu_si,
  output logic [WIDTH-1:0] alu_ai,
  output logic [WIDTH-1:0] alu_bi,
  output logic [WIDTH-1:0] alu_di,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_co,
  input  logic             alu_vo,
  input  logic             alu_zo,
  input  logic             alu_so
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_DIV, S_DFIN, S_RESP} state_t;

  state_t           r_state, w_next;
  logic [5:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_sh, r_q, r_rem, r_res, r_rsp_rem;
  logic             r_wf, r_dz;
  logic [3:0]       r_flags;   // {C,V,Z,S}
  logic [CW-1:0]    r_cnt;

  logic             w_req_div, w_req_dz;
  logic [WIDTH:0]   w_rem_sh, w_rem_diff;
  logic             w_ge;

  assign w_req_div = (req_op == OP_DIV);
  assign w_req_dz  = w_req_div && (req_b == '0);

  // Partial remainder kept one bit wider so large divisors never lose the MSB.
  assign w_rem_sh   = {r_rem, r_sh[WIDTH-1]};
  assign w_rem_diff = w_rem_sh - {1'b0, r_b};
  assign w_ge       = (w_rem_sh >= {1'b0, r_b});

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid) w_next = w_req_dz ? S_DFIN : (w_req_div ? S_DIV : S_EXEC);
      S_EXEC: w_next = S_RESP;
      S_DIV:  if (r_cnt == CW'(WIDTH-1)) w_next = S_DFIN;
      S_DFIN: w_next = S_RESP;
      S_RESP: if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_wf      <= 1'b0;
      r_dz      <= 1'b0;
      r_sh      <= '0;
      r_q       <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_res     <= '0;
      r_rsp_rem <= '0;
      r_flags   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_op  <= req_op;
          r_a   <= req_a;
          r_b   <= req_b;
          r_wf  <= req_wf;
          r_dz  <= w_req_dz;
          r_sh  <= req_a;
          r_cnt <= '0;
          // Divide by zero skips the iterations: quotient all ones, remainder = a.
          r_q   <= w_req_dz ? '1 : '0;
          r_rem <= w_req_dz ? req_a : '0;
        end
        S_EXEC: begin
          r_res     <= alu_res;
          r_rsp_rem <= '0;
          if (r_wf) r_flags <= {alu_co, alu_vo, alu_zo, alu_so};
        end
        S_DIV: begin
          r_sh  <= {r_sh[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt + CW'(1);
          r_q   <= {r_q[WIDTH-2:0], w_ge};
          r_rem <= w_ge ? w_rem_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
        end
        S_DFIN: begin
          r_res     <= alu_res;
          r_rsp_rem <= r_rem;
          if (r_wf) r_flags <= {r_flags[3], r_dz, alu_zo, alu_so};
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_res   = r_res;
  assign rsp_rem   = r_rsp_rem;
  assign {flag_c, flag_v, flag_z, flag_s} = r_flags;

  assign alu_op = r_op;
  assign alu_ai = r_a;
  assign alu_bi = r_b;
  assign alu_di = (r_op == OP_DIV) ? r_q : r_a;
  assign {alu_ci, alu_vi, alu_zi, alu_si} = r_flags;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: a small ALU model plus a vector table,
// followed by backpressure and reset-mid-divide sequences.
module tb_alu_seq_ctrl;
  localparam logic [5:0] OP_ADD = 6'd0, OP_ADC = 6'd1, OP_CMP = 6'd2, OP_XOR = 6'd3,
                         OP_STC = 6'd4, OP_CLC = 6'd5, OP_DIV = 6'd14;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       req_valid = 1'b0, req_ready, req_wf = 1'b0;
  logic [5:0] req_op = '0;
  logic [7:0] req_a = '0, req_b = '0;
  logic       rsp_valid, rsp_ready = 1'b1;
  logic [7:0] rsp_res, rsp_rem;
  logic       flag_c, flag_v, flag_z, flag_s;
  logic [5:0] alu_op;
  logic       alu_ci, alu_vi, alu_zi, alu_si;
  logic [7:0] alu_ai, alu_bi, alu_di, alu_res;
  logic       alu_co, alu_vo, alu_zo, alu_so;

  int total = 0, bad = 0;

  alu_seq_ctrl #(.WIDTH(8), .OP_DIV(OP_DIV)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_wf(req_wf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res), .rsp_rem(rsp_rem),
    .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z), .flag_s(flag_s),
    .alu_op(alu_op), .alu_ci(alu_ci), .alu_vi(alu_vi), .alu_zi(alu_zi), .alu_si(alu_si),
    .alu_ai(alu_ai), .alu_bi(alu_bi), .alu_di(alu_di), .alu_res(alu_res),
    .alu_co(alu_co), .alu_vo(alu_vo), .alu_zo(alu_zo), .alu_so(alu_so)
  );

  always #5 clk = ~clk;

  // Minimal ALU model: unlisted opcodes (incl. divide) return the bypass input.
  logic [8:0] m_sum;
  always_comb begin
    m_sum   = '0;
    alu_res = alu_di;
    alu_co  = alu_ci;
    alu_vo  = alu_vi;
    alu_zo  = (alu_di == 8'h00);
    alu_so  = alu_di[7];
    case (alu_op)
      OP_ADD, OP_ADC: begin
        m_sum   = {1'b0, alu_ai} + {1'b0, alu_bi} + ((alu_op == OP_ADC) ? {8'h00, alu_ci} : 9'h0);
        alu_res = m_sum[7:0];
        alu_co  = m_sum[8];
        alu_vo  = (alu_ai[7] == alu_bi[7]) && (m_sum[7] != alu_ai[7]);
        alu_zo  = (m_sum[7:0] == 8'h00);
        alu_so  = m_sum[7];
      end
      OP_CMP: begin
        m_sum   = {1'b0, alu_ai} + {1'b0, ~alu_bi} + 9'h1;
        alu_co  = m_sum[8];
        alu_vo  = (alu_ai[7] != alu_bi[7]) && (m_sum[7] != alu_ai[7]);
        alu_zo  = (m_sum[7:0] == 8'h00);
        alu_so  = m_sum[7];
      end
      OP_XOR: begin
        alu_res = alu_ai ^ alu_bi;
        alu_vo  = 1'b0;
        alu_zo  = ((alu_ai ^ alu_bi) == 8'h00);
        alu_so  = alu_ai[7] ^ alu_bi[7];
      end
      OP_STC: begin alu_co = 1'b1; alu_zo = alu_zi; alu_so = alu_si; end
      OP_CLC: begin alu_co = 1'b0; alu_zo = alu_zi; alu_so = alu_si; end
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {flag_c, flag_v, flag_z, flag_s};
  endfunction

  // Issue one op with rsp_ready=1; returns cycles from accept cycle to rsp_valid.
  task automatic issue(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic wf, output int lat);
    req_op = op; req_a = a; req_b = b; req_wf = wf; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  typedef struct {
    logic [5:0] op;
    logic [7:0] a, b;
    logic       wf;
    logic [7:0] res, rem;
    logic [3:0] fl;   // {C,V,Z,S}
    int         lat;
  } vec_t;

  vec_t tv[12];
  int   lat;
  logic [7:0] h_res, h_rem;
  logic [3:0] h_fl;
  logic seen;

  initial begin
    tv[0]  = '{OP_ADD, 8'h7F, 8'h01, 1'b1, 8'h80, 8'h00, 4'b0101, 2};
    tv[1]  = '{OP_STC, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 4'b1101, 2};
    tv[2]  = '{OP_ADC, 8'hFF, 8'h00, 1'b1, 8'h00, 8'h00, 4'b1010, 2};
    tv[3]  = '{OP_CMP, 8'h10, 8'h10, 1'b1, 8'h10, 8'h00, 4'b1010, 2};
    tv[4]  = '{OP_DIV, 8'hC8, 8'h07, 1'b1, 8'h1C, 8'h04, 4'b1000, 10};
    tv[5]  = '{OP_DIV, 8'h55, 8'h00, 1'b1, 8'hFF, 8'h55, 4'b1101, 2};
    tv[6]  = '{OP_XOR, 8'h0F, 8'hF0, 1'b0, 8'hFF, 8'h00, 4'b1101, 2};
    tv[7]  = '{OP_CLC, 8'h33, 8'h00, 1'b0, 8'h33, 8'h00, 4'b1101, 2};
    tv[8]  = '{OP_CLC, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 4'b0101, 2};
    tv[9]  = '{OP_DIV, 8'hFF, 8'h10, 1'b1, 8'h0F, 8'h0F, 4'b0000, 10};
    tv[10] = '{OP_DIV, 8'h00, 8'h03, 1'b1, 8'h00, 8'h00, 4'b0010, 10};
    tv[11] = '{OP_DIV, 8'hF0, 8'h81, 1'b0, 8'h01, 8'h6F, 4'b0010, 10};

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_flags", flags(), 0);
    chk("rst_res", rsp_res, 0);
    chk("rst_rem", rsp_rem, 0);

    for (int i = 0; i < 12; i++) begin
      issue(tv[i].op, tv[i].a, tv[i].b, tv[i].wf, lat);
      chk($sformatf("v%0d_lat", i), lat, tv[i].lat);
      chk($sformatf("v%0d_res", i), rsp_res, tv[i].res);
      chk($sformatf("v%0d_rem", i), rsp_rem, tv[i].rem);
      chk($sformatf("v%0d_flags", i), flags(), tv[i].fl);
      @(posedge clk); #1;
      chk($sformatf("v%0d_drop", i), {rsp_valid, req_ready}, 2'b01);
    end

    // Backpressure: response held while rsp_ready=0, requests ignored meanwhile.
    rsp_ready = 1'b0;
    issue(OP_ADD, 8'h80, 8'h80, 1'b1, lat);
    chk("bp_lat", lat, 2);
    h_res = rsp_res; h_rem = rsp_rem; h_fl = flags();
    chk("bp_res", h_res, 8'h00);
    chk("bp_flags", h_fl, 4'b1110);
    req_op = OP_DIV; req_a = 8'h12; req_b = 8'h00; req_wf = 1'b1; req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d", k),
          {rsp_valid, req_ready, rsp_res, rsp_rem, flags()},
          {1'b1, 1'b0, h_res, h_rem, h_fl});
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {rsp_valid, req_ready}, 2'b01);
    issue(OP_XOR, 8'h12, 8'h34, 1'b0, lat);
    chk("bp_xor_res", rsp_res, 8'h26);
    chk("bp_xor_flags", flags(), 4'b1110);
    @(posedge clk); #1;

    // Reset during divide iteration 3: no stale response afterwards.
    req_op = OP_DIV; req_a = 8'hC8; req_b = 8'h07; req_wf = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mrst_state", {rsp_valid, req_ready}, 2'b01);
    chk("mrst_flags", flags(), 0);
    chk("mrst_res", {rsp_res, rsp_rem}, 0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    chk("mrst_no_stale", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
